// File: rtl/dsa_step_controller.sv
// -----------------------------------------------------------------------------
// dsa_step_controller
//
// Run / halt / single-step sequencer for the bilinear-interpolation DSA core.
// JTAG debug commands drive it. It gates the sequential and SIMD datapath
// FSMs through dsa_step_en_o. It also produces the capture/ack strobes that
// the debug register bank consumes.
//
// Optional feature macro: DSA_STEP_BREAKPOINT_EN
//   defined   -> pixel-coordinate breakpoint (bp_x/bp_y/bp_arm, comparator,
//                one-cycle bp_skip after resuming) is built in.
//   undefined -> no breakpoint logic. bp_hit_o is tied low. SET_BP and CLR_BP
//                behave as NOPs.
//
// Ports
//   clk_i            : clock
//   rst_ni           : asynchronous active-low reset
//   cmd_valid_i      : command valid. A command is accepted on every valid cycle.
//   cmd_ready_o      : constant 1 outside reset
//   cmd_op_i [2:0]   : opcode (NOP, RUN, HALT, STEP, SET_BP, CLR_BP, CLR_STATUS, rsvd)
//   cmd_arg_i[31:0]  : opcode argument
//   current_x_i/y_i  : datapath output coordinate
//   dsa_done_i       : datapath finished the frame
//   dsa_step_en_o    : clock-enable for both datapath FSMs
//   capture_enable_o : high whenever the controller is not free-running
//   step_ack_o       : one-cycle pulse following each step enable
//   halted_o         : controller is HALTED
//   bp_hit_o         : sticky breakpoint-taken flag
//   cmd_err_o        : one-cycle pulse for a dropped or reserved command
//   steps_left_o     : remaining steps in the current burst
// -----------------------------------------------------------------------------
module dsa_step_controller #(
  parameter int STEP_W       = 16,
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [31:0]       cmd_arg_i,
  input  logic [15:0]       current_x_i,
  input  logic [15:0]       current_y_i,
  input  logic              dsa_done_i,
  output logic              dsa_step_en_o,
  output logic              capture_enable_o,
  output logic              step_ack_o,
  output logic              halted_o,
  output logic              bp_hit_o,
  output logic              cmd_err_o,
  output logic [STEP_W-1:0] steps_left_o
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_HALTED     = 2'd1,
    ST_STEP_ISSUE = 2'd2,
    ST_STEP_ACK   = 2'd3
  } state_t;

  localparam state_t RESET_STATE = RESET_HALTED ? ST_HALTED : ST_RUN;

  localparam logic [2:0] OP_RUN        = 3'd1;
  localparam logic [2:0] OP_HALT       = 3'd2;
  localparam logic [2:0] OP_STEP       = 3'd3;
  localparam logic [2:0] OP_SET_BP     = 3'd4;
  localparam logic [2:0] OP_CLR_BP     = 3'd5;
  localparam logic [2:0] OP_CLR_STATUS = 3'd6;
  localparam logic [2:0] OP_RSVD       = 3'd7;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   steps_left_q, steps_left_d;
  logic                cmd_err_q, cmd_err_d;
  logic                bp_match;
  logic [STEP_W-1:0]   step_arg;
  logic [STEP_W-1:0]   step_n;

  wire cmd_halt = cmd_valid_i && (cmd_op_i == OP_HALT);
  wire cmd_run  = cmd_valid_i && (cmd_op_i == OP_RUN);
  wire cmd_step = cmd_valid_i && (cmd_op_i == OP_STEP);

  assign step_arg = cmd_arg_i[STEP_W-1:0];
  // A zero-length burst would never issue an enable, so it is promoted to one step.
  assign step_n   = (step_arg == '0) ? STEP_W'(1) : step_arg;

`ifdef DSA_STEP_BREAKPOINT_EN
  logic        bp_arm_q;
  logic [15:0] bp_x_q, bp_y_q;
  logic        bp_skip_q;
  logic        bp_hit_q;

  assign bp_match = (state_q == ST_RUN) && bp_arm_q && !bp_skip_q &&
                    (current_x_i == bp_x_q) && (current_y_i == bp_y_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bp_arm_q  <= 1'b0;
      bp_x_q    <= '0;
      bp_y_q    <= '0;
      bp_skip_q <= 1'b0;
      bp_hit_q  <= 1'b0;
    end else begin
      if (cmd_valid_i && cmd_op_i == OP_SET_BP) begin
        bp_arm_q <= 1'b1;
        bp_x_q   <= cmd_arg_i[15:0];
        bp_y_q   <= cmd_arg_i[31:16];
      end else if (cmd_valid_i && cmd_op_i == OP_CLR_BP) begin
        bp_arm_q <= 1'b0;
      end
      // Masks the comparator for the first RUN cycle after resuming.
      // Without it the datapath, still parked on the breakpoint pixel,
      // would trap again at once.
      bp_skip_q <= (state_q == ST_HALTED) && cmd_run;
      // Taking a breakpoint wins over a CLR_STATUS in the same cycle.
      if (bp_match)
        bp_hit_q <= 1'b1;
      else if (cmd_valid_i && cmd_op_i == OP_CLR_STATUS)
        bp_hit_q <= 1'b0;
    end
  end

  assign bp_hit_o = bp_hit_q;
`else
  logic unused_bp;
  assign unused_bp = ^{current_x_i, current_y_i, cmd_arg_i};
  assign bp_match  = 1'b0;
  assign bp_hit_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RESET_STATE;
      steps_left_q <= '0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_left_q <= steps_left_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    steps_left_d = steps_left_q;
    cmd_err_d    = cmd_valid_i && (cmd_op_i == OP_RSVD);
    case (state_q)
      ST_RUN: begin
        if (bp_match || cmd_halt) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (cmd_run) begin
          state_d = ST_RUN;
        end else if (cmd_step) begin
          state_d      = ST_STEP_ISSUE;
          steps_left_d = step_n;
        end
      end
      ST_STEP_ISSUE: begin
        // The enable of this cycle completes even when HALT arrives now.
        state_d = ST_STEP_ACK;
        if (cmd_halt) begin
          state_d      = ST_HALTED;
          steps_left_d = '0;
        end
      end
      ST_STEP_ACK: begin
        if (cmd_halt || dsa_done_i || steps_left_q == STEP_W'(1)) begin
          state_d      = ST_HALTED;
          steps_left_d = '0;
        end else begin
          state_d      = ST_STEP_ISSUE;
          steps_left_d = steps_left_q - STEP_W'(1);
        end
      end
      default: state_d = RESET_STATE;
    endcase
    // A burst in flight cannot be restarted or converted to free-run.
    if ((state_q == ST_STEP_ISSUE || state_q == ST_STEP_ACK) && (cmd_run || cmd_step))
      cmd_err_d = 1'b1;
  end

  assign cmd_ready_o      = rst_ni;
  assign dsa_step_en_o    = rst_ni && ((state_q == ST_STEP_ISSUE) ||
                                       (state_q == ST_RUN && !bp_match));
  assign capture_enable_o = (state_q != ST_RUN);
  assign halted_o         = (state_q == ST_HALTED);
  assign step_ack_o       = (state_q == ST_STEP_ACK);
  assign cmd_err_o        = cmd_err_q;
  assign steps_left_o     = steps_left_q;

endmodule

// File: doc/dsa_step_controller.md
# dsa_step_controller

Run/halt/single-step sequencer for the bilinear-interpolation DSA core, driven by JTAG debug commands. Gates the sequential and SIMD datapath FSMs through a clock-enable and generates the `capture_enable` / `step_ack` strobes consumed by the debug register bank. Sits between the JTAG command interface and `dsa_top`. It also supplies an optional pixel-coordinate breakpoint.

## Interface

**Parameters**
- `STEP_W`, default 16: step-count width.
- `RESET_HALTED`, default 0: state after reset. 0 gives RUN; 1 gives HALTED.

**Ports**
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cmd_valid` in 1: JTAG command valid.
- `cmd_ready` out 1: command accept. Constant 1 outside reset.
- `cmd_op` in 3: opcode.
- `cmd_arg` in 32: opcode argument.
- `current_x` in 16: datapath output x coordinate.
- `current_y` in 16: datapath output y coordinate.
- `dsa_done` in 1: datapath finished the frame.
- `dsa_step_en` out 1: enable for both datapath FSMs.
- `capture_enable` out 1: 1 whenever the state is not RUN.
- `step_ack` out 1: one-cycle pulse after each executed step.
- `halted` out 1: state is HALTED.
- `bp_hit` out 1: sticky flag, breakpoint taken.
- `cmd_err` out 1: one-cycle pulse when a command is dropped or reserved.
- `steps_left` out STEP_W: remaining steps in the current burst.

## Operation

**Opcodes**

A command is accepted on any cycle where `cmd_valid` is high.
- 0 NOP
- 1 RUN
- 2 HALT
- 3 STEP: N = `cmd_arg[STEP_W-1:0]`. N=0 is treated as 1.
- 4 SET_BP: bp_y = `cmd_arg[31:16]`, bp_x = `cmd_arg[15:0]`. Sets bp_arm.
- 5 CLR_BP: clears bp_arm.
- 6 CLR_STATUS: clears `bp_hit`.
- 7 reserved: no effect, `cmd_err` pulses next cycle.

**States:** RUN, HALTED, STEP_ISSUE, STEP_ACK.

**RUN**
- `dsa_step_en` = !bp_match.
- bp_match = bp_arm & !bp_skip & (`current_x`==bp_x) & (`current_y`==bp_y).
- On bp_match: go to HALTED and set `bp_hit`. The datapath is frozen in the same cycle, holding the matching coordinate.
- On HALT: go to HALTED.

**HALTED**
- `dsa_step_en`=0.
- On RUN: go to RUN and set bp_skip for exactly the first RUN cycle, so leaving a breakpoint coordinate does not re-trigger.
- On STEP: load `steps_left`=N and go to STEP_ISSUE.

**STEP_ISSUE**
- `dsa_step_en`=1 for one cycle, then go to STEP_ACK.

**STEP_ACK**
- `step_ack`=1 and `steps_left` decrements.
- If the new `steps_left` is 0, or `dsa_done`=1: set `steps_left` to 0 and go to HALTED.
- Otherwise go to STEP_ISSUE.

**Commands during STEP_ISSUE / STEP_ACK**
- HALT: abort. Clear `steps_left` and go to HALTED on the next edge. If received in STEP_ISSUE, the enable pulse of that cycle still completes.
- NOP, SET_BP, CLR_BP, CLR_STATUS: executed normally.
- RUN, STEP: dropped, with a `cmd_err` pulse.

**Breakpoints**
- Breakpoints are evaluated only in RUN. Stepping ignores them.
- `dsa_done` has no effect in RUN or HALTED.

## Timing

**Reset values (`rst_n` low)**
- `cmd_ready`=0 and `dsa_step_en`=0, forced while in reset.
- `step_ack`=0, `bp_hit`=0, `cmd_err`=0, `steps_left`=0.
- bp_arm=0, bp_x=0, bp_y=0.
- State = RESET_HALTED ? HALTED : RUN.
- `halted` = RESET_HALTED; `capture_enable` = RESET_HALTED.
- Reset asserted mid-burst abandons the burst immediately.

**Output timing**
- `dsa_step_en` and `capture_enable` are combinational from state, plus bp_match in RUN.
- `step_ack`, `cmd_err` and `halted` are registered state decodes.

**STEP N accepted at cycle 0 in HALTED**
- `dsa_step_en` is high in cycles 1, 3, …, 2N−1.
- `step_ack` is high in cycles 2, 4, …, 2N.
- `halted` is high from cycle 2N+1.
- `step_ack` always follows its enable by exactly one cycle, so debug capture sees post-step values.

**Other command latencies**
- HALT in RUN: `dsa_step_en` low from cycle 1.
- RUN in HALTED: `dsa_step_en` high from cycle 1.
- Breakpoint: `dsa_step_en` low in the same cycle as the coordinate match, and `bp_hit` high the next cycle.

**Simultaneous events**
- HALT and bp_match in the same cycle: go to HALTED with `bp_hit` set.
- CLR_STATUS and a breakpoint hit in the same cycle: set wins.

## Configuration

`DSA_STEP_BREAKPOINT_EN`
- Defined: bp_x/bp_y/bp_arm registers, the comparator and bp_skip are compiled in. Behaviour is as described above.
- Undefined: none of that logic exists. bp_match=0 and `bp_hit` is tied to 0. SET_BP and CLR_BP are accepted as NOPs with no `cmd_err`.

## Test plan

- Reset with RESET_HALTED=0 → `dsa_step_en`=1 and `capture_enable`=0 on the first post-reset cycle. HALT → `dsa_step_en`=0 next cycle and `halted`=1.
- From HALTED, STEP with arg=3 → exactly 3 enable pulses alternating with 3 `step_ack` pulses; `steps_left` goes 2,1,0; `halted` returns at cycle 7.
- STEP with arg=0 → exactly one enable pulse and one ack.
- SET_BP arg=0x0005_000A, then RUN, with coordinates incrementing → `dsa_step_en` drops in the cycle where x=10, y=5, and `bp_hit`=1 next cycle. RUN again → enable stays high through the matching cycle; no re-halt.
- STEP arg=100, then HALT at cycle 4 → `halted` at cycle 5 and `steps_left`=0. A STEP issued mid-burst → `cmd_err` pulse, burst length unchanged.
- `dsa_done`=1 during the second STEP_ACK of a STEP 10 → HALTED next cycle with `steps_left`=0. Opcode 7 → `cmd_err` pulse and no state change.
